// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared encodings for the iterative RV32M multiply/divide unit.
//   OP_*      funct3 encodings of the M-extension ops
//   state_t   sequencer FSM states
//   is_div / is_signed_a / is_signed_b   op classification helpers
package muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {IDLE, ITER, FIXUP, DONE} state_t;

  function automatic logic is_div(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
  endfunction

  // MUL is not listed: its low word is identical for signed and unsigned operands.
  function automatic logic is_signed_a(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_signed_b(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if: execute-stage <-> mul/div unit signals.
//   master: execute stage (drives start_e, op_e, src_a_e, src_b_e, flush_e)
//   slave : muldiv_sequencer (drives stall_e, busy, result_valid, result)
interface muldiv_sequencer_if #(
  parameter int XLEN = 32
);
  logic            start_e;
  logic [2:0]      op_e;
  logic [XLEN-1:0] src_a_e;
  logic [XLEN-1:0] src_b_e;
  logic            flush_e;
  logic            stall_e;
  logic            busy;
  logic            result_valid;
  logic [XLEN-1:0] result;

  modport master (
    output start_e, op_e, src_a_e, src_b_e, flush_e,
    input  stall_e, busy, result_valid, result
  );

  modport slave (
    input  start_e, op_e, src_a_e, src_b_e, flush_e,
    output stall_e, busy, result_valid, result
  );
endinterface

// File: rtl/muldiv_fixup.sv
// muldiv_fixup: combinational sign/word selection after the unsigned iteration.
//   op          latched funct3
//   aNeg, bNeg  operand was negative and is treated as signed for this op
//   bZero       divisor was zero (quotient must stay all-ones)
//   prod        2*XLEN magnitude product
//   quot, rem   magnitude quotient / remainder
//   result      final architectural result
module muldiv_fixup
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]        op,
  input  logic              aNeg,
  input  logic              bNeg,
  input  logic              bZero,
  input  logic [2*XLEN-1:0] prod,
  input  logic [XLEN-1:0]   quot,
  input  logic [XLEN-1:0]   rem,
  output logic [XLEN-1:0]   result
);
  logic            negP;
  logic [XLEN-1:0] hiS;

  // High word of the negated product: ~hi plus the carry out of ~lo + 1,
  // which only happens when the low word is zero.
  assign negP = aNeg ^ bNeg;
  assign hiS  = negP ? (~prod[2*XLEN-1:XLEN] + XLEN'(prod[XLEN-1:0] == '0))
                     : prod[2*XLEN-1:XLEN];

  always_comb begin
    result = '0;
    case (op)
      OP_MUL:             result = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU: result = hiS;
      OP_MULHU:           result = prod[2*XLEN-1:XLEN];
      // Divide by zero yields all-ones regardless of dividend sign.
      OP_DIV, OP_DIVU:    result = (negP && !bZero) ? -quot : quot;
      OP_REM, OP_REMU:    result = aNeg ? -rem : rem;
      default:            result = '0;
    endcase
  end
endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative RV32M multiply/divide unit beside the E-stage ALU.
//   clk, rst    clock, async active-low reset
//   bus.slave   start_e/op_e/src_a_e/src_b_e/flush_e in;
//               stall_e (comb), busy, result_valid, result (registered) out
// Runs on operand magnitudes (shift-add multiply / restoring divide), one
// bit per cycle, then fixes signs. Holds F/D/E through stall_e while working
// and pulses result_valid in DONE, the cycle E advances.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int FAST_SPECIAL = 1
) (
  input  logic              clk,
  input  logic              rst,
  muldiv_sequencer_if.slave bus
);
  localparam int CW = $clog2(XLEN);
  localparam int AW = 2*XLEN + 1;

  state_t          state, nextState;
  logic            busyR, resultValidR;
  logic [XLEN-1:0] resultR;
  logic [2:0]      opR;
  logic            aNeg, bNeg, bZero;
  logic [XLEN-1:0] magB;
  logic [AW-1:0]   acc;
  logic [CW-1:0]   cnt;

  // ---- operand decode in IDLE ----
  logic            aSgn, bSgn, divZero, divOvf, special, accept;
  logic [XLEN-1:0] magAIn, magBIn, specialRes;

  assign accept  = bus.start_e & ~bus.flush_e;
  assign aSgn    = is_signed_a(bus.op_e) & bus.src_a_e[XLEN-1];
  assign bSgn    = is_signed_b(bus.op_e) & bus.src_b_e[XLEN-1];
  assign magAIn  = aSgn ? -bus.src_a_e : bus.src_a_e;
  assign magBIn  = bSgn ? -bus.src_b_e : bus.src_b_e;
  assign divZero = (bus.src_b_e == '0);
  assign divOvf  = is_signed_a(bus.op_e) && (bus.src_a_e == {1'b1, {(XLEN-1){1'b0}}})
                   && (bus.src_b_e == '1);
  assign special = (FAST_SPECIAL != 0) && is_div(bus.op_e) && (divZero || divOvf);
  // op_e[1] separates REM/REMU from DIV/DIVU; the overflow dividend is itself the DIV answer.
  assign specialRes = divZero ? (bus.op_e[1] ? bus.src_a_e : '1)
                              : (bus.op_e[1] ? '0 : bus.src_a_e);

  // ---- one radix-2 step ----
  // Multiply: acc = {partial product, unconsumed multiplier}; add, shift right.
  logic [XLEN:0]   mulSum;
  logic [AW-1:0]   mulNext;
  assign mulSum  = acc[AW-1:XLEN] + {1'b0, magB};
  assign mulNext = acc[0] ? {1'b0, mulSum, acc[XLEN-1:1]} : {1'b0, acc[AW-1:1]};

  // Divide: acc = {partial remainder, dividend/quotient}; shift left, trial subtract.
  logic [AW-1:0]   shl, divNext;
  logic [XLEN:0]   trial;
  assign shl     = {acc[AW-2:0], 1'b0};
  assign trial   = shl[AW-1:XLEN] - {1'b0, magB};
  assign divNext = trial[XLEN] ? shl : {trial, shl[XLEN-1:1], 1'b1};

  logic [XLEN-1:0] fixRes;
  muldiv_fixup #(.XLEN(XLEN)) uFixup (
    .op    (opR),
    .aNeg  (aNeg),
    .bNeg  (bNeg),
    .bZero (bZero),
    .prod  (acc[2*XLEN-1:0]),
    .quot  (acc[XLEN-1:0]),
    .rem   (acc[2*XLEN-1:XLEN]),
    .result(fixRes)
  );

  // ---- FSM ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      busyR <= 1'b0;
    end else begin
      state <= nextState;
      busyR <= (nextState != IDLE);
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:  if (accept) nextState = special ? DONE : ITER;
      ITER:  if (cnt == CW'(XLEN-1)) nextState = FIXUP;
      FIXUP: nextState = DONE;
      DONE:  nextState = IDLE;
    endcase
    if (bus.flush_e) nextState = IDLE;
  end

  // ---- datapath ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resultValidR <= 1'b0;
      resultR      <= '0;
      opR          <= '0;
      aNeg         <= 1'b0;
      bNeg         <= 1'b0;
      bZero        <= 1'b0;
      magB         <= '0;
      acc          <= '0;
      cnt          <= '0;
    end else if (bus.flush_e) begin
      resultValidR <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          resultValidR <= 1'b0;
          if (bus.start_e) begin
            opR   <= bus.op_e;
            aNeg  <= aSgn;
            bNeg  <= bSgn;
            bZero <= divZero;
            magB  <= magBIn;
            acc   <= {{(XLEN+1){1'b0}}, magAIn};
            cnt   <= '0;
            if (special) begin
              resultR      <= specialRes;
              resultValidR <= 1'b1;
            end
          end
        end
        ITER: begin
          acc <= is_div(opR) ? divNext : mulNext;
          cnt <= cnt + 1'b1;
        end
        FIXUP: begin
          resultR      <= fixRes;
          resultValidR <= 1'b1;
        end
        DONE: resultValidR <= 1'b0;
      endcase
    end
  end

  // E stays held from the accept cycle through FIXUP; a flush releases it at once.
  assign bus.stall_e      = ~bus.flush_e & (((state == IDLE) & bus.start_e) |
                                            (state == ITER) | (state == FIXUP));
  assign bus.busy         = busyR;
  assign bus.result_valid = resultValidR;
  assign bus.result       = resultR;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: two instances (FAST_SPECIAL=1 and 0) checked against a
// plain-arithmetic RV32M model, plus flush, held-start and reset scenarios.
module tb_muldiv_sequencer;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  muldiv_sequencer_if #(.XLEN(XLEN)) bf ();
  muldiv_sequencer_if #(.XLEN(XLEN)) bs ();

  muldiv_sequencer #(.XLEN(XLEN), .FAST_SPECIAL(1)) dutF (.clk(clk), .rst(rst), .bus(bf));
  muldiv_sequencer #(.XLEN(XLEN), .FAST_SPECIAL(0)) dutS (.clk(clk), .rst(rst), .bus(bs));

  int nChk = 0;
  int nErr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChk++;
    if (obs !== exp) begin
      nErr++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // ---- reference model ----
  function automatic logic [31:0] refMd(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    logic        ovf;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin p = ua * ub; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit isSpecial(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    return (op >= 3'd4) && ((b == 0) ||
           ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // ---- bus access (sel 0 = fast instance, 1 = slow instance) ----
  task automatic setIn(input bit sel, input logic st, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic fl);
    if (sel) begin
      bs.start_e = st; bs.op_e = op; bs.src_a_e = a; bs.src_b_e = b; bs.flush_e = fl;
    end else begin
      bf.start_e = st; bf.op_e = op; bf.src_a_e = a; bf.src_b_e = b; bf.flush_e = fl;
    end
  endtask

  task automatic getOut(input bit sel, output logic st, output logic bz, output logic rv,
                        output logic [31:0] res);
    if (sel) begin st = bs.stall_e; bz = bs.busy; rv = bs.result_valid; res = bs.result; end
    else     begin st = bf.stall_e; bz = bf.busy; rv = bf.result_valid; res = bf.result; end
  endtask

  // Issue one op and watch a fixed window; hold keeps start_e up until the
  // result cycle, as a stalled E stage would.
  task automatic runOp(input bit sel, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input bit hold);
    logic st, bz, rv;
    logic [31:0] res, got;
    int nStall, nRv, rvAt, expStall;
    logic busyAfter;
    expStall  = (!sel && isSpecial(op, a, b)) ? 1 : XLEN + 2;
    nStall    = 0; nRv = 0; rvAt = -1; got = '0; busyAfter = 1'b1;
    @(negedge clk);
    setIn(sel, 1'b1, op, a, b, 1'b0);
    for (int c = 0; c < XLEN + 6; c++) begin
      #1;
      getOut(sel, st, bz, rv, res);
      if (st) nStall++;
      if (rv) begin nRv++; rvAt = c; got = res; end
      if (c == expStall + 1) busyAfter = bz;
      @(negedge clk);
      if (!hold || rv) setIn(sel, 1'b0, op, a, b, 1'b0);
    end
    chk($sformatf("stall s%0d op%0d", sel, op), nStall, expStall);
    chk($sformatf("rvcount s%0d op%0d", sel, op), nRv, 1);
    chk($sformatf("rvcycle s%0d op%0d", sel, op), rvAt, expStall);
    chk($sformatf("result s%0d op%0d a=%h b=%h", sel, op, a, b), got, refMd(op, a, b));
    chk($sformatf("busyafter s%0d op%0d", sel, op), 32'(busyAfter), 32'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(15));
      default: return $urandom;
    endcase
  endfunction

  localparam int ND = 14;
  localparam logic [2:0]  D_OP [ND] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
                                        3'd5, 3'd6, 3'd4, 3'd6, 3'd4, 3'd6};
  localparam logic [31:0] D_A  [ND] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                        32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                                        32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000,
                                        32'hFFFF_FFFB, 32'hFFFF_FFFB};
  localparam logic [31:0] D_B  [ND] = '{32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2,
                                        32'd2, 32'd2, 32'd7, 32'd7,
                                        32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                        32'd0, 32'd0};

  initial begin
    logic st, bz, rv;
    logic [31:0] res;
    bit seenRv;

    setIn(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    setIn(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      getOut(s[0], st, bz, rv, res);
      chk("reset stall", 32'(st), 32'd0);
      chk("reset busy", 32'(bz), 32'd0);
      chk("reset rv", 32'(rv), 32'd0);
      chk("reset result", res, 32'd0);
    end
    rst = 1'b1;

    // directed table on both instances
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < ND; i++)
        runOp(s[0], D_OP[i], D_A[i], D_B[i], 1'b0);

    // start_e held through DONE: one result only
    runOp(1'b0, 3'd0, 32'd12, 32'd11, 1'b1);
    runOp(1'b0, 3'd5, 32'd5, 32'd0, 1'b1);

    // flush in ITER cycle 10
    @(negedge clk);
    setIn(1'b0, 1'b1, 3'd0, 32'd7, 32'd6, 1'b0);
    repeat (10) @(negedge clk);
    setIn(1'b0, 1'b1, 3'd0, 32'd7, 32'd6, 1'b1);
    #1 chk("flush stall", 32'(bf.stall_e), 32'd0);
    @(negedge clk);
    setIn(1'b0, 1'b0, 3'd0, 32'd7, 32'd6, 1'b0);
    #1 chk("flush busy", 32'(bf.busy), 32'd0);
    seenRv = 1'b0;
    for (int c = 0; c < XLEN + 6; c++) begin
      @(negedge clk);
      #1 if (bf.result_valid) seenRv = 1'b1;
    end
    chk("flush no result", 32'(seenRv), 32'd0);
    runOp(1'b0, 3'd0, 32'd3, 32'd3, 1'b0);

    // reset mid-ITER on both
    @(negedge clk);
    setIn(1'b0, 1'b1, 3'd0, 32'd5, 32'd5, 1'b0);
    setIn(1'b1, 1'b1, 3'd4, 32'd50, 32'd5, 1'b0);
    @(negedge clk);
    setIn(1'b0, 1'b0, 3'd0, 32'd5, 32'd5, 1'b0);
    setIn(1'b1, 1'b0, 3'd4, 32'd50, 32'd5, 1'b0);
    repeat (8) @(negedge clk);
    chk("busy before rst", 32'(bf.busy), 32'd1);
    rst = 1'b0;
    #1;
    for (int s = 0; s < 2; s++) begin
      getOut(s[0], st, bz, rv, res);
      chk("rst mid busy", 32'(bz), 32'd0);
      chk("rst mid stall", 32'(st), 32'd0);
      chk("rst mid rv", 32'(rv), 32'd0);
      chk("rst mid result", res, 32'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    runOp(1'b0, 3'd5, 32'd100, 32'd7, 1'b0);
    runOp(1'b1, 3'd7, 32'd100, 32'd7, 1'b0);

    // randomized ops on both instances
    for (int i = 0; i < 60; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      op = 3'($urandom_range(7));
      a  = pick();
      b  = pick();
      runOp(i[0], op, a, b, ($urandom_range(3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nChk, nErr);
    $finish;
  end
endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Iterative RV32M multiply/divide unit with its own sequencing FSM, sitting beside the execute-stage ALU. It accepts one M-extension operation from the execute stage, holds the pipeline (F/D/E) via stall_e while it iterates, then presents the result for one cycle so the execute stage captures it into its E→M register. It shares no state with the ALU; the hazard unit ORs stall_e into the front-end stalls.

Parameters:
XLEN, 32, operand/result width; also the iteration count.
FAST_SPECIAL, 1, when 1 divide-by-zero and signed overflow bypass iteration (1-cycle stall).

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
start_e  in  1  valid M-op in execute stage
op_e  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
src_a_e  in  XLEN  rs1 value after forwarding
src_b_e  in  XLEN  rs2 value after forwarding
flush_e  in  1  kill the in-flight op (branch/jump flush of E)
stall_e  out  1  hold F/D/E registers (combinational)
busy  out  1  FSM not IDLE (registered)
result_valid  out  1  result present this cycle (registered, one-cycle pulse)
result  out  XLEN  operation result, valid only with result_valid

Behaviour:
- Reset (rst low, async): state IDLE, result_valid 0, result 0, busy 0, all internal registers 0; a reset mid-operation abandons the op with no result.
- States: IDLE, ITER, FIXUP, DONE.
- IDLE: start_e & ~flush_e at an edge -> latch op, operand magnitudes, sign flags, count<=0, state ITER. Special case with FAST_SPECIAL=1: divisor 0, or signed DIV/REM with a=0x80000000 and b=0xFFFFFFFF -> load result directly, state DONE.
- ITER: one radix-2 step per cycle. Multiply: shift-add on a 2*XLEN accumulator. Divide: restoring step on magnitudes. count increments; at count==XLEN-1 -> FIXUP.
- FIXUP: apply sign. MUL takes the low word. MULH/MULHSU negate the 64-bit product when the operand signs differ (MULHSU: b is treated as unsigned) and take the high word. MULHU takes the high word. DIV negates the quotient when the signs differ. REM takes the sign of the dividend. -> DONE.
- DONE: result_valid=1 for exactly this cycle; -> IDLE unconditionally. start_e is ignored in DONE because the same instruction is still in E.
- stall_e = (state==IDLE & start_e & ~flush_e) | state==ITER | state==FIXUP. It is low in DONE, so E advances on the edge leaving DONE and captures result.
- Latency, normal op: stall_e high for XLEN+2 consecutive cycles (accept cycle, XLEN ITER cycles, FIXUP). result_valid is high in the next cycle. Special op: stall_e high 1 cycle, result_valid next cycle.
- Special results: DIV/DIVU by 0 -> 0xFFFFFFFF. REM/REMU by 0 -> dividend. Signed overflow: DIV -> 0x80000000, REM -> 0. With FAST_SPECIAL=0 the iteration plus fixup must produce the same values.
- flush_e: synchronous, and has priority over start_e and every state transition. At the edge it forces state IDLE and result_valid 0. No result is produced afterwards, and stall_e drops combinationally in the same cycle.
- Back-to-back: a new start_e is accepted in the first IDLE cycle after DONE. The minimum gap between two result_valid pulses is XLEN+3 cycles.
- All arithmetic is modulo 2^XLEN. The internal accumulator is 2*XLEN+1 bits; the counter is clog2(XLEN) bits.

Decomposition:
- Package muldiv_pkg holds: the op encoding localparams (OP_MUL..OP_REMU), the state encoding (IDLE/ITER/FIXUP/DONE), and helpers is_div(op) and is_signed_a/is_signed_b(op).
- One sub-module, muldiv_fixup (combinational): takes the raw product/quotient/remainder, the sign flags and op, and returns the final result. The FSM, counter and iteration datapath stay in muldiv_sequencer.

Test Plan:
- MUL a=7 b=6, start 1 cycle -> stall_e high 34 cycles, then result_valid=1 with result=0x0000002A for 1 cycle; busy low the cycle after.
- MULH a=b=0xFFFFFFFF -> 0x00000000; MULHU same operands -> 0xFFFFFFFE; MULHSU a=0xFFFFFFFF b=2 -> 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (-7) b=2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Specials (FAST_SPECIAL=1): DIVU 5/0 -> stall_e 1 cycle, then 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0. Repeat with FAST_SPECIAL=0 -> same values after 34 stall cycles.
- flush_e pulsed in ITER cycle 10 -> stall_e low that cycle, no result_valid ever, FSM back in IDLE; next start_e (MUL 3*3) -> 9 with normal latency.
- start_e held high through DONE -> exactly one result_valid; rst pulsed low mid-ITER -> busy, stall_e, result_valid and result 0 immediately; after release, a new op completes normally.
